coeff_loader: RTL and testbench
===============================

Name: coeff_loader

Overview:
- Write-side sequencer for the AHB convolver's coefficient register bank.
- Accepts a burst of NUM_COEFF 16-bit coefficient words over a valid/ready stream from the AHB slave.
- Drives the bank's load interface (coeff_ld, coeff_sel, coeff_in), one registered load pulse per accepted word, indices 0..NUM_COEFF-1.
- Signals set completion, and aborts or times out cleanly on incomplete bursts.

Parameters:
- NUM_COEFF, 3, coefficients per set; must be 2..4 so the index fits SEL_W.
- DATA_W, 16, coefficient word width.
- SEL_W, 2, coefficient select width.
- TIMEOUT_CYC, 16, consecutive idle cycles tolerated mid-burst before error; must be ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- wr_valid  in  1  upstream word valid.
- wr_data  in  DATA_W  upstream coefficient word, signed two's complement.
- wr_ready  out  1  loader can accept a word this cycle.
- abort  in  1  cancel the in-progress set.
- err_clr  in  1  clear sticky load_err.
- coeff_ld  out  1  single-cycle load strobe to the coefficient bank.
- coeff_sel  out  SEL_W  coefficient index for coeff_ld.
- coeff_in  out  DATA_W  coefficient value for coeff_ld.
- load_busy  out  1  a set is partially loaded.
- load_done  out  1  one-cycle pulse when a full set has been loaded.
- load_err  out  1  sticky: the last set was aborted or timed out.

Behaviour:
- Reset (async, rst=1): state IDLE, index 0, timeout counter 0. All outputs 0, including wr_ready, coeff_ld, coeff_sel, coeff_in, load_busy, load_done and load_err. Reset mid-burst discards the partial set with no further coeff_ld.
- Accept: a word is accepted when wr_valid & wr_ready at the clock edge.
- Load latency: exactly 1 cycle. The cycle after an accept has coeff_ld=1, coeff_sel=index at accept, coeff_in=wr_data at accept. coeff_ld is 0 on every other cycle. coeff_sel and coeff_in hold their last values when coeff_ld=0.
- FSM states: IDLE, LOAD, DONE, ERR.
- IDLE: wr_ready=1. An accept sets index to 1 and moves to LOAD, unless NUM_COEFF would be reached, in which case it moves to DONE. abort is ignored in IDLE.
- LOAD: wr_ready=1, load_busy=1.
  - Accept: increment index and clear the timeout counter. If this was the word at index NUM_COEFF-1, go to DONE.
  - No accept: increment the timeout counter. When it reaches TIMEOUT_CYC, go to ERR.
- DONE: one cycle. wr_ready=0. load_done=1, coincident with the coeff_ld of the last word. Index returns to 0; next state IDLE.
- ERR: one cycle. wr_ready=0. Set load_err and reset index and timeout counter to 0; next state IDLE. Bank entries already written in the aborted set are not restored.
- abort in LOAD: go to ERR next cycle. If abort coincides with wr_valid, wr_ready is still 1 but abort wins: the word is not accepted and no coeff_ld is issued.
- load_err: cleared by err_clr. If err_clr and ERR entry occur in the same cycle, set wins. A successful set does not clear it.
- Timeout counter width: clog2(TIMEOUT_CYC+1); no wrap.
- Back-to-back bursts: wr_valid held high gives accepts in every IDLE/LOAD cycle. There is a 1-cycle bubble in DONE between sets.

Optional Feature:
- Macro: COEFF_LOADER_SAT_EN.
- Defined: coeff_in is wr_data saturated to the signed 12-bit range. Values above 2047 become 0x07FF; values below -2048 become 0xF800 (sign-extended to DATA_W). This keeps the 12-bit slice the bank uses correct.
- Undefined: coeff_in = wr_data unmodified.
- FSM timing is identical either way.

Decomposition:
- Package coeff_loader_pkg contains:
  - state enum coeff_ld_state_t {IDLE, LOAD, DONE, ERR}
  - localparams COEFF_OUT_W=12, SAT_MAX=16'sh07FF, SAT_MIN=16'shF800
- One sub-module, coeff_sat: combinational DATA_W-to-COEFF_OUT_W signed saturator. Instantiated only under COEFF_LOADER_SAT_EN.

Test Plan:
- Reset/basic load: assert rst mid-cycle, then release. All outputs are 0 and wr_ready rises 1 cycle after release. Words 0x0011, 0x0022, 0x0033 on consecutive cycles give coeff_ld pulses with sel 0/1/2 carrying those values. load_done is 1 with the sel=2 pulse, then wr_ready=0 for one cycle.
- Stalled burst: accept 0x0100, idle 5 cycles, then send 0x0200 and 0x0300. Loads land at sel 0/1/2, load_done pulses once, load_err stays 0.
- Timeout: accept one word, then wr_valid=0 for 16 cycles. ERR is entered, load_err=1, load_busy falls. The next word 0x0AAA loads at sel=0.
- Abort collision: in LOAD assert abort and wr_valid with 0x0BBB in the same cycle. There is no coeff_ld for 0x0BBB and load_err=1. Then err_clr gives load_err=0; err_clr coincident with a new ERR keeps load_err=1.
- Reset mid-burst: after 2 of 3 words, pulse rst. No further coeff_ld appears; the next burst starts at sel=0.
- Saturation (COEFF_LOADER_SAT_EN): 0x7FFF→0x07FF, 0x8000→0xF800, 0x0123→0x0123. With the macro undefined, 0x7FFF passes through unchanged.

Source files
------------

// File: rtl/coeff_loader_pkg.sv
// Shared types and constants for the coefficient loader.
// Optional feature macro: COEFF_LOADER_SAT_EN (clamps loaded words to signed 12 bits).
package coeff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } coeff_ld_state_t;

  // Width of the slice the coefficient bank actually consumes
  localparam int COEFF_OUT_W = 12;

  // Signed 12-bit limits, sign-extended to a 16-bit word
  localparam logic signed [15:0] SAT_MAX = 16'sh07FF;
  localparam logic signed [15:0] SAT_MIN = 16'shF800;

endpackage

// File: rtl/coeff_sat.sv
// Combinational signed saturator: clamps a DATA_W word into the signed
// COEFF_OUT_W range, result sign-extended back to DATA_W.
module coeff_sat
  import coeff_loader_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] din,
  output logic        [DATA_W-1:0] dout
);

  localparam logic signed [DATA_W-1:0] MAX_S = DATA_W'(SAT_MAX);
  localparam logic signed [DATA_W-1:0] MIN_S = DATA_W'(SAT_MIN);

  // Clamp above the positive limit and below the negative limit
  always_comb begin
    dout = din;
    if (din > MAX_S) begin
      dout = MAX_S;
    end else if (din < MIN_S) begin
      dout = MIN_S;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/coeff_loader.sv
// Write-side sequencer for the convolver coefficient bank. Accepts a burst of
// NUM_COEFF words over valid/ready and issues one registered load strobe per
// accepted word; flags completion, abort and mid-burst timeout.
// Optional feature macro: COEFF_LOADER_SAT_EN (saturate coeff_in to signed 12 bits).
module coeff_loader
  import coeff_loader_pkg::*;
#(
  parameter int NUM_COEFF   = 3,
  parameter int DATA_W      = 16,
  parameter int SEL_W       = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              abort,
  input  logic              err_clr,
  output logic              coeff_ld,
  output logic [SEL_W-1:0]  coeff_sel,
  output logic [DATA_W-1:0] coeff_in,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int               TCNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_COEFF - 1);
  localparam logic [TCNT_W-1:0] TO_LAST = TCNT_W'(TIMEOUT_CYC - 1);

  coeff_ld_state_t    state_r;
  logic [SEL_W-1:0]   idx_r;
  logic [TCNT_W-1:0]  tcnt_r;
  logic               accept_s;
  logic               last_s;
  logic [DATA_W-1:0]  coeff_val_s;

`ifdef COEFF_LOADER_SAT_EN
  coeff_sat #(
    .DATA_W (DATA_W)
  ) u_coeff_sat (
    .din  (wr_data),
    .dout (coeff_val_s)
  );
`else
  assign coeff_val_s = wr_data;
`endif

  // abort beats a coincident word while a set is in progress
  assign accept_s = wr_valid & wr_ready & ~(abort & (state_r == LOAD));
  assign last_s   = (idx_r == LAST_IDX);

  // Sequencer FSM with registered handshake, status and bank-load outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      tcnt_r    <= '0;
      wr_ready  <= 1'b0;
      coeff_ld  <= 1'b0;
      coeff_sel <= '0;
      coeff_in  <= '0;
      load_busy <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      coeff_ld  <= 1'b0;
      load_done <= 1'b0;
      if (accept_s) begin
        coeff_ld  <= 1'b1;
        coeff_sel <= idx_r;
        coeff_in  <= coeff_val_s;
      end
      // Clear first so an ERR entry in the same cycle overrides it below
      if (err_clr) begin
        load_err <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          tcnt_r <= '0;
          if (accept_s && last_s) begin
            state_r   <= DONE;
            idx_r     <= '0;
            wr_ready  <= 1'b0;
            load_busy <= 1'b0;
            load_done <= 1'b1;
          end else if (accept_s) begin
            state_r   <= LOAD;
            idx_r     <= idx_r + SEL_W'(1);
            wr_ready  <= 1'b1;
            load_busy <= 1'b1;
          end else begin
            wr_ready  <= 1'b1;
            load_busy <= 1'b0;
          end
        end
        LOAD: begin
          if (abort) begin
            state_r   <= ERR;
            wr_ready  <= 1'b0;
            load_busy <= 1'b0;
            load_err  <= 1'b1;
          end else if (accept_s) begin
            tcnt_r <= '0;
            if (last_s) begin
              state_r   <= DONE;
              idx_r     <= '0;
              wr_ready  <= 1'b0;
              load_busy <= 1'b0;
              load_done <= 1'b1;
            end else begin
              idx_r <= idx_r + SEL_W'(1);
            end
          end else begin
            tcnt_r <= tcnt_r + TCNT_W'(1);
            if (tcnt_r == TO_LAST) begin
              state_r   <= ERR;
              wr_ready  <= 1'b0;
              load_busy <= 1'b0;
              load_err  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r   <= IDLE;
          idx_r     <= '0;
          tcnt_r    <= '0;
          wr_ready  <= 1'b1;
          load_busy <= 1'b0;
        end
        ERR: begin
          state_r   <= IDLE;
          idx_r     <= '0;
          tcnt_r    <= '0;
          wr_ready  <= 1'b1;
          load_busy <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          idx_r     <= '0;
          tcnt_r    <= '0;
          wr_ready  <= 1'b0;
          load_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_loader.sv
// Directed self-checking bench for coeff_loader.
module tb_coeff_loader;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        abort;
  logic        err_clr;
  logic        coeff_ld;
  logic [1:0]  coeff_sel;
  logic [15:0] coeff_in;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  int n_total  = 0;
  int n_passed = 0;

  coeff_loader dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .abort     (abort),
    .err_clr   (err_clr),
    .coeff_ld  (coeff_ld),
    .coeff_sel (coeff_sel),
    .coeff_in  (coeff_in),
    .load_busy (load_busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bank value for a written word
  function automatic logic [15:0] exp_in(input logic [15:0] d);
`ifdef COEFF_LOADER_SAT_EN
    logic signed [15:0] s;
    s = d;
    if (s > 16'sh07FF) return 16'h07FF;
    else if (s < 16'shF800) return 16'hF800;
    else return d;
`else
    return d;
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expect a load pulse with the given index, data and done flag
  task automatic ld_chk(input string tag, input logic [1:0] sel, input logic [15:0] d,
                        input logic done);
    check({tag, "_ld"},   16'(coeff_ld),  16'd1);
    check({tag, "_sel"},  16'(coeff_sel), 16'(sel));
    check({tag, "_in"},   coeff_in,       exp_in(d));
    check({tag, "_done"}, 16'(load_done), 16'(done));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; wr_valid = 1'b0; wr_data = 16'h0000; abort = 1'b0; err_clr = 1'b0;

    // Reset asserted mid-cycle
    #3 rst = 1'b1;
    #1;
    check("rst_ready", 16'(wr_ready),  16'd0);
    check("rst_ld",    16'(coeff_ld),  16'd0);
    check("rst_sel",   16'(coeff_sel), 16'd0);
    check("rst_in",    coeff_in,       16'h0000);
    check("rst_busy",  16'(load_busy), 16'd0);
    check("rst_done",  16'(load_done), 16'd0);
    check("rst_err",   16'(load_err),  16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rel_ready0", 16'(wr_ready), 16'd0);
    cyc();
    check("rel_ready1", 16'(wr_ready), 16'd1);

    // Basic back-to-back load
    wr_valid = 1'b1; wr_data = 16'h0011; cyc(); ld_chk("b0", 2'd0, 16'h0011, 1'b0);
    check("b0_busy", 16'(load_busy), 16'd1);
    wr_data = 16'h0022; cyc(); ld_chk("b1", 2'd1, 16'h0022, 1'b0);
    wr_data = 16'h0033; cyc(); ld_chk("b2", 2'd2, 16'h0033, 1'b1);
    check("b2_ready", 16'(wr_ready),  16'd0);
    check("b2_busy",  16'(load_busy), 16'd0);
    wr_valid = 1'b0; cyc();
    check("b_idle_ld",   16'(coeff_ld),  16'd0);
    check("b_idle_done", 16'(load_done), 16'd0);
    check("b_idle_rdy",  16'(wr_ready),  16'd1);
    check("b_hold_sel",  16'(coeff_sel), 16'd2);
    check("b_hold_in",   coeff_in,       exp_in(16'h0033));

    // Stalled burst
    wr_valid = 1'b1; wr_data = 16'h0100; cyc(); ld_chk("s0", 2'd0, 16'h0100, 1'b0);
    wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("s_gap_ld",   16'(coeff_ld),  16'd0);
      check("s_gap_busy", 16'(load_busy), 16'd1);
    end
    wr_valid = 1'b1; wr_data = 16'h0200; cyc(); ld_chk("s1", 2'd1, 16'h0200, 1'b0);
    wr_data = 16'h0300; cyc(); ld_chk("s2", 2'd2, 16'h0300, 1'b1);
    wr_valid = 1'b0; cyc();
    check("s_err",  16'(load_err),  16'd0);
    check("s_done", 16'(load_done), 16'd0);

    // Timeout: 15 idle cycles stay in LOAD, the 16th enters ERR
    wr_valid = 1'b1; wr_data = 16'h0400; cyc(); ld_chk("t0", 2'd0, 16'h0400, 1'b0);
    wr_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      check("t_wait_busy", 16'(load_busy), 16'd1);
      check("t_wait_err",  16'(load_err),  16'd0);
    end
    cyc();
    check("t_err",   16'(load_err),  16'd1);
    check("t_busy",  16'(load_busy), 16'd0);
    check("t_ready", 16'(wr_ready),  16'd0);
    cyc();
    check("t_idle_rdy", 16'(wr_ready), 16'd1);
    check("t_sticky",   16'(load_err), 16'd1);

    // New word after timeout starts at sel 0; err_clr clears the flag
    wr_valid = 1'b1; wr_data = 16'h0AAA; err_clr = 1'b1;
    cyc(); ld_chk("t_next", 2'd0, 16'h0AAA, 1'b0);
    check("clr_err", 16'(load_err), 16'd0);
    err_clr = 1'b0;

    // Abort collides with a word in LOAD
    abort = 1'b1; wr_data = 16'h0BBB; cyc();
    check("ab_ld",    16'(coeff_ld), 16'd0);
    check("ab_in",    coeff_in,      exp_in(16'h0AAA));
    check("ab_err",   16'(load_err), 16'd1);
    check("ab_ready", 16'(wr_ready), 16'd0);
    abort = 1'b0; wr_valid = 1'b0; cyc();
    check("ab_idle_ld", 16'(coeff_ld), 16'd0);
    err_clr = 1'b1; cyc();
    check("ab_clr", 16'(load_err), 16'd0);
    err_clr = 1'b0;

    // err_clr coincident with a new ERR entry: set wins
    wr_valid = 1'b1; wr_data = 16'h0CCC; cyc(); ld_chk("c0", 2'd0, 16'h0CCC, 1'b0);
    wr_valid = 1'b0; abort = 1'b1; err_clr = 1'b1; cyc();
    check("c_setwins", 16'(load_err), 16'd1);
    abort = 1'b0; err_clr = 1'b0; cyc();
    check("c_sticky", 16'(load_err), 16'd1);

    // abort is ignored in IDLE
    wr_valid = 1'b1; abort = 1'b1; wr_data = 16'h0DDD; cyc();
    ld_chk("i_abort", 2'd0, 16'h0DDD, 1'b0);
    abort = 1'b0;
    wr_data = 16'h0EEE; cyc(); ld_chk("i_w1", 2'd1, 16'h0EEE, 1'b0);

    // Reset mid-burst after two of three words
    wr_data = 16'h0456;
    #2 rst = 1'b1;
    #1;
    check("mr_ld",   16'(coeff_ld),  16'd0);
    check("mr_busy", 16'(load_busy), 16'd0);
    check("mr_rdy",  16'(wr_ready),  16'd0);
    @(posedge clk); #1;
    check("mr_ld2", 16'(coeff_ld), 16'd0);
    rst = 1'b0;
    cyc();
    check("mr_ld3", 16'(coeff_ld), 16'd0);
    check("mr_rdy2", 16'(wr_ready), 16'd1);
    cyc(); ld_chk("mr_w0", 2'd0, 16'h0456, 1'b0);

    // Saturation boundaries (pass-through when the feature is off)
    wr_data = 16'h7FFF; cyc(); ld_chk("sat_pos", 2'd1, 16'h7FFF, 1'b0);
    wr_data = 16'h8000; cyc(); ld_chk("sat_neg", 2'd2, 16'h8000, 1'b1);
    wr_valid = 1'b0; cyc();
    wr_valid = 1'b1; wr_data = 16'h0123; cyc(); ld_chk("sat_mid", 2'd0, 16'h0123, 1'b0);
    wr_valid = 1'b0; cyc();

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
